// File: rtl/freq_meter_pkg.sv
// -----------------------------------------------------------------------------
// freq_meter_pkg
// Shared types and defaults for the frequency meter.
//   state_t          : measurement FSM state, 2-bit encoding
//   DEF_GATE_CYCLES  : default gate window length in clk cycles
//   DEF_CNT_W        : default width of the edge counter / count_out
//   DEF_GATE_W       : default width of the gate counter
//   params_ok()      : helper that tells whether a gate/width pairing is legal
// -----------------------------------------------------------------------------
package freq_meter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    DONE    = 2'd2
  } state_t;

  localparam int DEF_GATE_CYCLES = 64;
  localparam int DEF_CNT_W       = 16;
  localparam int DEF_GATE_W      = 16;

  // The gate counter has to reach GATE_CYCLES (one past the last window
  // cycle) without wrapping, and a window needs at least two cycles.
  function automatic bit params_ok(input int gate_cycles, input int gate_w);
    longint unsigned span;
    span = longint'(64'd1) << gate_w;
    return (gate_cycles >= 2) && (span > longint'(gate_cycles));
  endfunction

endpackage

// File: rtl/freq_meter_if.sv
// -----------------------------------------------------------------------------
// freq_meter_if
// Control and result bundle of the frequency meter.
//   start     : level request to begin one measurement
//   cont      : continuous mode, re-arm the window after every result
//   sig_in    : asynchronous signal under test
//   busy      : meter is measuring or presenting a result
//   valid     : one-cycle result strobe
//   count_out : rising-edge count of the last completed window
//   overflow  : last window saturated the edge counter
// modport master drives the requests and observes results; modport slave is
// the meter itself.
// -----------------------------------------------------------------------------
interface freq_meter_if
  import freq_meter_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
);

  logic             start;
  logic             cont;
  logic             sig_in;
  logic             busy;
  logic             valid;
  logic [CNT_W-1:0] count_out;
  logic             overflow;

  modport master (
    output start,
    output cont,
    output sig_in,
    input  busy,
    input  valid,
    input  count_out,
    input  overflow
  );

  modport slave (
    input  start,
    input  cont,
    input  sig_in,
    output busy,
    output valid,
    output count_out,
    output overflow
  );

endinterface

// File: rtl/freq_meter_sync_edge_det.sv
// -----------------------------------------------------------------------------
// sync_edge_det
// Brings an asynchronous level into the clk domain through a two-flop
// synchronizer and emits a single-cycle pulse for every rising edge seen on
// the synchronized level.
//   clk      : sampling clock
//   rst      : synchronous, active-low reset, clears every flop
//   async_in : asynchronous input level
//   edge_out : one-cycle pulse, 2 to 3 clk cycles after a rising async_in
// Runs continuously; callers decide in which states a pulse matters.
// -----------------------------------------------------------------------------
module sync_edge_det
  import freq_meter_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic edge_out
);

  // s1 may go metastable; only s2 and s3 are used downstream.
  logic s1_reg;
  logic s2_reg;
  logic s3_reg;

  always_ff @(posedge clk) begin
    if (!rst) begin
      s1_reg <= 1'b0;
      s2_reg <= 1'b0;
      s3_reg <= 1'b0;
    end else begin
      s1_reg <= async_in;
      s2_reg <= s1_reg;
      s3_reg <= s2_reg;
    end
  end

  assign edge_out = s2_reg & ~s3_reg;

endmodule

// File: rtl/freq_meter.sv
// -----------------------------------------------------------------------------
// freq_meter
// Counts rising edges of an asynchronous square wave over a fixed window of
// GATE_CYCLES clk cycles and reports the count with a one-cycle valid strobe.
//   clk : system clock
//   rst : synchronous, active-low reset
//   bus : freq_meter_if.slave (start, cont, sig_in in; busy, valid,
//         count_out, overflow out)
// Parameters:
//   GATE_CYCLES : window length in clk cycles (>= 2)
//   CNT_W       : edge counter / count_out width
//   GATE_W      : gate counter width, 2**GATE_W > GATE_CYCLES
// Timing: start accepted in IDLE -> GATE_CYCLES MEASURE cycles -> one DONE
// cycle with valid high. In continuous mode windows repeat every
// GATE_CYCLES+1 cycles; edges landing in IDLE or DONE are dropped.
// -----------------------------------------------------------------------------
module freq_meter
  import freq_meter_pkg::*;
#(
  parameter int GATE_CYCLES = DEF_GATE_CYCLES,
  parameter int CNT_W       = DEF_CNT_W,
  parameter int GATE_W      = DEF_GATE_W
) (
  input logic        clk,
  input logic        rst,
  freq_meter_if.slave bus
);

  localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
  localparam logic [GATE_W-1:0] GATE_ONE  = GATE_W'(1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

  state_t state_reg;
  state_t state_next;

  logic [GATE_W-1:0] gate_reg;
  logic [GATE_W-1:0] gate_next;
  logic [CNT_W-1:0]  cnt_reg;
  logic [CNT_W-1:0]  cnt_next;
  logic              ovf_reg;
  logic              ovf_next;

  logic [CNT_W-1:0]  count_out_reg;
  logic              overflow_reg;

  logic edge_pulse;
  logic in_measure;
  logic last_gate;
  logic clear_win;
  logic cnt_sat;

  // ---------------------------------------------------------------------------
  // Input conditioning
  // ---------------------------------------------------------------------------
  sync_edge_det u_sync (
    .clk      (clk),
    .rst      (rst),
    .async_in (bus.sig_in),
    .edge_out (edge_pulse)
  );

  assign in_measure = (state_reg == MEASURE);
  assign last_gate  = (gate_reg == GATE_LAST);
  assign cnt_sat    = (cnt_reg == CNT_MAX);

  // A new window opens from IDLE on start, or straight out of DONE when the
  // meter is re-armed; both paths clear the counters.
  assign clear_win = ((state_reg == IDLE) && bus.start) ||
                     ((state_reg == DONE) && (bus.cont || bus.start));

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (bus.start) begin
          state_next = MEASURE;
        end
      end
      MEASURE: begin
        // start is deliberately ignored here: no queuing, no restart.
        if (last_gate) begin
          state_next = DONE;
        end
      end
      DONE: begin
        if (bus.cont || bus.start) begin
          state_next = MEASURE;
        end else begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    bus.busy  = (state_reg == MEASURE) || (state_reg == DONE);
    bus.valid = (state_reg == DONE);
  end

  // ---------------------------------------------------------------------------
  // Window counters
  // ---------------------------------------------------------------------------
  always_comb begin
    gate_next = gate_reg;
    cnt_next  = cnt_reg;
    ovf_next  = ovf_reg;
    if (clear_win) begin
      gate_next = '0;
      cnt_next  = '0;
      ovf_next  = 1'b0;
    end else if (in_measure) begin
      // On the last window cycle the gate counter steps to GATE_CYCLES;
      // it is never compared again before the next clear.
      gate_next = gate_reg + GATE_ONE;
      if (edge_pulse) begin
        if (cnt_sat) begin
          ovf_next = 1'b1;
        end else begin
          cnt_next = cnt_reg + CNT_ONE;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      gate_reg <= '0;
      cnt_reg  <= '0;
      ovf_reg  <= 1'b0;
    end else begin
      gate_reg <= gate_next;
      cnt_reg  <= cnt_next;
      ovf_reg  <= ovf_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Result registers: loaded from the *next* counter values on the last
  // window cycle so that cycle's edge is included, then held until the
  // following window closes.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      count_out_reg <= '0;
      overflow_reg  <= 1'b0;
    end else if (in_measure && last_gate) begin
      count_out_reg <= cnt_next;
      overflow_reg  <= ovf_next;
    end
  end

  assign bus.count_out = count_out_reg;
  assign bus.overflow  = overflow_reg;

endmodule

// File: doc/freq_meter.md
Name: freq_meter

Overview:
- Measures the frequency of an asynchronous square-wave input against the system clock by counting its rising edges over a fixed gate window of GATE_CYCLES clk cycles.
- Acts as the observing end of the team's clock-divider outputs: it checks div2/div4/div8-style derived clocks and any external slow clock, and reports the edge count with a one-cycle valid pulse.
- Sits in the test and monitor area of the design and drives a status register or self-check logic.

Parameters:
- GATE_CYCLES, 64: length of the measurement window in clk cycles; must be at least 2.
- CNT_W, 16: width of the edge counter and of count_out.
- GATE_W, 16: width of the gate counter; must satisfy 2**GATE_W > GATE_CYCLES.

Ports:
- clk  in  1  system clock; every flop samples on its rising edge.
- rst  in  1  reset, synchronous, active-low; clears all state when sampled low at a clk rising edge.
- start  in  1  level request to begin one measurement; accepted only in IDLE.
- cont  in  1  continuous mode; when high, a new window starts directly after DONE without needing start.
- sig_in  in  1  signal under test, asynchronous to clk.
- busy  out  1  high in MEASURE and DONE.
- valid  out  1  one-cycle pulse in DONE; count_out and overflow are meaningful while it is high.
- count_out  out  CNT_W  rising-edge count of the last completed window; held until the next DONE.
- overflow  out  1  set when the last window's edge count exceeded 2**CNT_W-1; held with count_out.

Behaviour:
- Reset (rst low at a clk edge):
  - State goes to IDLE.
  - busy=0, valid=0, count_out=0, overflow=0.
  - Synchronizer flops, edge-detect flop, gate counter and edge counter all clear to 0.
  - Reset has priority over every other event, including mid-MEASURE; a partial count is discarded and never reported.
- Input conditioning:
  - sig_in passes through a 2-flop synchronizer (s1, s2) and then a delay flop s3.
  - edge = s2 & ~s3, which is a single-cycle pulse per rising edge.
  - Latency from a sig_in rising edge to the edge pulse is 2 to 3 clk cycles.
  - Only rising edges are counted.
  - Sampling requires sig_in high and low phases of at least 1 clk period each, so inputs up to clk/2 measure exactly. Faster inputs alias, and no error is flagged.
- FSM states:
  - IDLE: when start=1, clear the gate and edge counters and go to MEASURE next cycle.
  - MEASURE:
    - The gate counter increments every cycle, from 0 up to GATE_CYCLES-1.
    - An edge pulse in any MEASURE cycle increments the edge counter. Exactly GATE_CYCLES cycles are sampled.
    - In the cycle where the gate counter equals GATE_CYCLES-1, that cycle's edge is still counted, and the next state is DONE.
  - DONE (exactly one cycle):
    - valid=1, and count_out/overflow show the final values; they are registered on entry to DONE, so they are stable during the valid cycle.
    - Next state is MEASURE, with counters cleared, if cont=1 or start=1.
    - Otherwise the next state is IDLE.
- Saturation: the edge counter saturates at 2**CNT_W-1. Any edge arriving while it is saturated sets an internal ovf flag, which is cleared at window start.
- start is ignored in MEASURE; there is no queuing and no restart.
- Deasserting cont during MEASURE does not abort the window. It only affects the decision taken in DONE.
- Synchronizer and edge-detect flops run in every state. An edge that occurs in IDLE or DONE is not counted.
- In continuous mode the back-to-back period is GATE_CYCLES+1 cycles: one idle DONE cycle in which edges are dropped.

Decomposition:
- Shared package freq_meter_pkg holds:
  - the state enum (IDLE, MEASURE, DONE), encoded in 2 bits;
  - constants for the default GATE_CYCLES and CNT_W.
- One natural sub-module, sync_edge_det:
  - 2-flop synchronizer plus rising-edge pulse, with clk and rst (synchronous, active-low);
  - reusable by other blocks that take in asynchronous signals.

Test Plan:
- sig_in toggles every clk cycle (period 2), GATE_CYCLES=16, start pulse -> one valid pulse 17 cycles after start is accepted; count_out=8, overflow=0; busy high for 17 cycles.
- sig_in with period 8 (a div8-style clock from the team's divider), GATE_CYCLES=64 -> count_out=8; with period 4 -> count_out=16.
- sig_in held at 0, and separately held at 1 -> count_out=0, overflow=0.
- CNT_W=3, sig_in with period 2, GATE_CYCLES=16 -> count_out=7, overflow=1; the next window with sig_in at 0 -> count_out=0, overflow=0.
- rst driven low for 1 cycle halfway through MEASURE -> next cycle has busy=0, valid=0, count_out=0; no valid pulse follows without a new start.
- cont=1 with sig_in period 4, GATE_CYCLES=16 -> valid pulses every 17 cycles, each with count_out=4; a start pulse during MEASURE has no effect on timing.
